// File: rtl/backgr_removal_div_pkg.sv
// Shared types and helpers for the sequential signed divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package backgr_removal_div_pkg;

  // Default operand width used by the arithmetic cores of the datapath.
  localparam int DEFAULT_WIDTH = 32;

  // The divider steps through three phases.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Counter width that can hold W-1.
  // The width is never below 1, so a degenerate W=1 still gets a real register.
  function automatic int clog2(input int w);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < w) r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/backgr_removal_udiv_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
// Latency: combinational.
// Backpressure: none.
module backgr_removal_udiv_step #(
  parameter int W = 32
) (
  input  logic [W:0] rem_in,
  input  logic [W:0] divisor,
  input  logic       bit_in,
  output logic [W:0] rem_out,
  output logic       q_bit
);

  logic [W+1:0] shifted;
  logic [W+1:0] diff;

  // The partial remainder always stays below 2^W.
  // The top bit of the W+2-bit difference is therefore an exact borrow flag.
  always_comb begin
    shifted = {rem_in, bit_in};
    diff    = shifted - {1'b0, divisor};
    q_bit   = ~diff[W+1];
    rem_out = q_bit ? diff[W:0] : shifted[W:0];
  end

endmodule

// File: rtl/backgr_removal_sdiv_seq.sv
// Sequential signed divider: radix-2 restoring, one quotient bit per enabled cycle.
// Latency: W+2 enabled cycles from start to done inclusive.
// Backpressure: start is ignored unless the core is IDLE; ce low freezes everything.
module backgr_removal_sdiv_seq
  import backgr_removal_div_pkg::*;
#(
  parameter int ID         = 1,
  parameter int DIN0_WIDTH = DEFAULT_WIDTH,
  parameter int DIN1_WIDTH = DEFAULT_WIDTH,
  parameter int DOUT_WIDTH = DEFAULT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  start,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  output logic                  busy,
  output logic                  done,
  output logic                  div_by_zero,
  output logic [DOUT_WIDTH-1:0] quot,
  output logic [DOUT_WIDTH-1:0] rem
);

  localparam int W  = DIN0_WIDTH;
  localparam int CW = clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  // The results share the dividend width.
  // The divisor is sign-extended up to that width, never truncated.
  if (DOUT_WIDTH != DIN0_WIDTH || DIN1_WIDTH > DIN0_WIDTH || ID < 0) begin : g_bad_cfg
    $error("backgr_removal_sdiv_seq: unsupported parameter combination");
  end

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [W-1:0]  dvd;      // |dividend|, consumed MSB first
  logic [W:0]    dsr;      // |divisor|, one extra bit so |MIN| is exact
  logic [W-1:0]  q;
  logic [W:0]    r;
  logic          sign_q, sign_r, zero;

  logic [W:0]    din1_ext, din1_abs;
  logic [W-1:0]  din0_abs;
  logic [W:0]    step_r;
  logic          step_q;
  logic [W-1:0]  q_next;
  logic [W-1:0]  q_neg;
  logic [W:0]    r_neg;
  logic [W-1:0]  fix_quot, fix_rem;

  // Operand magnitudes at accept.
  // The final step result is sign-fixed so the outputs are ready in the done cycle.
  always_comb begin
    din0_abs = din0[W-1] ? ('0 - din0) : din0;
    din1_ext = (W + 1)'($signed(din1));
    din1_abs = din1_ext[W] ? ('0 - din1_ext) : din1_ext;
    q_next   = {q[W-2:0], step_q};
    q_neg    = '0 - q_next;
    r_neg    = '0 - step_r;
    fix_quot = zero ? '1 : (sign_q ? q_neg : q_next);
    fix_rem  = sign_r ? r_neg[W-1:0] : step_r[W-1:0];
  end

  backgr_removal_udiv_step #(.W(W)) u_step (
    .rem_in  (r),
    .divisor (dsr),
    .bit_in  (dvd[W-1]),
    .rem_out (step_r),
    .q_bit   (step_q)
  );

  // State register; it advances only on enabled cycles.
  always_ff @(posedge clk) begin
    if (reset)   state <= IDLE;
    else if (ce) state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (cnt == LAST) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, the iteration datapath, and the result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      dvd         <= '0;
      dsr         <= '0;
      q           <= '0;
      r           <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      zero        <= 1'b0;
      quot        <= '0;
      rem         <= '0;
      div_by_zero <= 1'b0;
    end else if (ce) begin
      case (state)
        IDLE: begin
          if (start) begin
            dvd    <= din0_abs;
            dsr    <= din1_abs;
            sign_q <= din0[W-1] ^ din1[DIN1_WIDTH-1];
            sign_r <= din0[W-1];
            zero   <= (din1 == '0);
            q      <= '0;
            r      <= '0;
            cnt    <= '0;
          end
        end
        CALC: begin
          r   <= step_r;
          q   <= q_next;
          dvd <= {dvd[W-2:0], 1'b0};
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            cnt         <= '0;
            quot        <= fix_quot;
            rem         <= fix_rem;
            div_by_zero <= zero;
          end
        end
        default: ;
      endcase
    end
  end

  // The done pulse is gated by ce.
  // While stalled in FIX it stays low and fires once when ce returns.
  always_comb begin
    busy = (state != IDLE);
    done = (state == FIX) && ce;
  end

endmodule

// File: tb/tb_backgr_removal_sdiv_seq.sv
// Directed bench for the sequential signed divider.
module tb_backgr_removal_sdiv_seq;

  logic        clk = 1'b0;
  logic        reset, ce, start;
  logic [31:0] din0, din1;
  logic        busy, done, div_by_zero;
  logic [31:0] quot, rem;

  int total = 0;
  int bad   = 0;

  // Results captured by run_op.
  int          r_lat, r_busy, r_extra;
  logic [31:0] r_quot, r_rem;
  logic        r_dbz;

  always #5 clk = ~clk;

  backgr_removal_sdiv_seq #(
    .ID(1), .DIN0_WIDTH(32), .DIN1_WIDTH(32), .DOUT_WIDTH(32)
  ) dut (
    .clk(clk), .reset(reset), .ce(ce), .start(start),
    .din0(din0), .din1(din1),
    .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .quot(quot), .rem(rem)
  );

  // Cycle numbering: the start cycle is cycle 1.
  // ce is held low at the ends of cycles ce_at .. ce_at+ce_len-1.
  // start is re-pulsed during cycle restart_at.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input int ce_at, input int ce_len, input int restart_at);
    int cyc;
    bit seen;
    @(negedge clk);
    ce = 1'b1; din0 = a; din1 = b; start = 1'b1;
    cyc = 1; seen = 0;
    r_lat = -1; r_busy = 0; r_extra = 0;
    r_quot = 'x; r_rem = 'x; r_dbz = 1'bx;
    while (!seen && cyc < 80) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (busy) r_busy++;
      if (done) begin
        seen = 1; r_lat = cyc;
        r_quot = quot; r_rem = rem; r_dbz = div_by_zero;
      end
      if (cyc == ce_at) ce = 1'b0;
      if (cyc == ce_at + ce_len) ce = 1'b1;
      if (cyc == restart_at) start = 1'b1;
    end
    ce = 1'b1; start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) r_extra++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; ce = 1'b1; start = 1'b0; din0 = '0; din1 = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dbz got=%b exp=0", div_by_zero); end
    total++; if (quot !== 32'd0) begin bad++; $display("FAIL reset_quot got=%h exp=0", quot); end
    total++; if (rem !== 32'd0) begin bad++; $display("FAIL reset_rem got=%h exp=0", rem); end
  endtask

  task automatic test_basic();
    run_op(32'd100, 32'd7, 0, 0, 0);
    total++; if (r_lat != 34) begin bad++; $display("FAIL basic_latency got=%0d exp=34", r_lat); end
    total++; if (r_busy != 33) begin bad++; $display("FAIL basic_busy_cycles got=%0d exp=33", r_busy); end
    total++; if (r_quot !== 32'd14) begin bad++; $display("FAIL basic_quot got=%h exp=%h", r_quot, 32'd14); end
    total++; if (r_rem !== 32'd2) begin bad++; $display("FAIL basic_rem got=%h exp=%h", r_rem, 32'd2); end
    total++; if (r_dbz !== 1'b0) begin bad++; $display("FAIL basic_dbz got=%b exp=0", r_dbz); end
    total++; if (r_extra != 0) begin bad++; $display("FAIL basic_single_done extra=%0d exp=0", r_extra); end
    total++; if (quot !== 32'd14 || busy !== 1'b0) begin
      bad++; $display("FAIL basic_hold quot=%h busy=%b exp quot=%h busy=0", quot, busy, 32'd14);
    end
  endtask

  task automatic test_signs();
    logic [31:0] va [3];
    logic [31:0] vb [3];
    logic [31:0] eq [3];
    logic [31:0] er [3];
    va = '{-32'sd100, 32'd100, -32'sd100};
    vb = '{32'd7, -32'sd7, -32'sd7};
    eq = '{-32'sd14, -32'sd14, 32'd14};
    er = '{-32'sd2, 32'd2, -32'sd2};
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], 0, 0, 0);
      total++; if (r_quot !== eq[i]) begin bad++; $display("FAIL sign_quot[%0d] got=%h exp=%h", i, r_quot, eq[i]); end
      total++; if (r_rem !== er[i]) begin bad++; $display("FAIL sign_rem[%0d] got=%h exp=%h", i, r_rem, er[i]); end
    end
  endtask

  task automatic test_min();
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
    total++; if (r_quot !== 32'h8000_0000) begin bad++; $display("FAIL min_neg1_quot got=%h exp=80000000", r_quot); end
    total++; if (r_rem !== 32'd0) begin bad++; $display("FAIL min_neg1_rem got=%h exp=0", r_rem); end
    total++; if (r_dbz !== 1'b0) begin bad++; $display("FAIL min_neg1_dbz got=%b exp=0", r_dbz); end
    run_op(32'h8000_0000, 32'd1, 0, 0, 0);
    total++; if (r_quot !== 32'h8000_0000) begin bad++; $display("FAIL min_1_quot got=%h exp=80000000", r_quot); end
    total++; if (r_rem !== 32'd0) begin bad++; $display("FAIL min_1_rem got=%h exp=0", r_rem); end
  endtask

  task automatic test_div_zero();
    run_op(32'd5, 32'd0, 0, 0, 0);
    total++; if (r_lat != 34) begin bad++; $display("FAIL dz_latency got=%0d exp=34", r_lat); end
    total++; if (r_quot !== 32'hFFFF_FFFF) begin bad++; $display("FAIL dz_quot got=%h exp=ffffffff", r_quot); end
    total++; if (r_rem !== 32'd5) begin bad++; $display("FAIL dz_rem got=%h exp=5", r_rem); end
    total++; if (r_dbz !== 1'b1) begin bad++; $display("FAIL dz_flag got=%b exp=1", r_dbz); end
    run_op(32'd6, 32'd3, 0, 0, 0);
    total++; if (r_quot !== 32'd2) begin bad++; $display("FAIL dz_next_quot got=%h exp=2", r_quot); end
    total++; if (r_rem !== 32'd0) begin bad++; $display("FAIL dz_next_rem got=%h exp=0", r_rem); end
    total++; if (r_dbz !== 1'b0) begin bad++; $display("FAIL dz_next_flag got=%b exp=0", r_dbz); end
  endtask

  task automatic test_ce_stall();
    run_op(32'd1000, 32'd10, 10, 5, 20);
    total++; if (r_lat != 39) begin bad++; $display("FAIL stall_latency got=%0d exp=39", r_lat); end
    total++; if (r_quot !== 32'd100) begin bad++; $display("FAIL stall_quot got=%h exp=%h", r_quot, 32'd100); end
    total++; if (r_rem !== 32'd0) begin bad++; $display("FAIL stall_rem got=%h exp=0", r_rem); end
    total++; if (r_extra != 0) begin bad++; $display("FAIL stall_single_done extra=%0d exp=0", r_extra); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL stall_no_queue busy=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    int dones;
    @(negedge clk);
    ce = 1'b1; din0 = 32'd1000; din1 = 32'd7; start = 1'b1;
    for (int c = 2; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1; start = 1'b1;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rstmid_done got=%b exp=0", done); end
    total++; if (quot !== 32'd0 || rem !== 32'd0) begin
      bad++; $display("FAIL rstmid_outputs quot=%h rem=%h exp 0/0", quot, rem);
    end
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    total++; if (dones != 0) begin bad++; $display("FAIL rstmid_activity got=%0d exp=0", dones); end
    run_op(32'd9, 32'd2, 0, 0, 0);
    total++; if (r_lat != 34) begin bad++; $display("FAIL rstmid_next_latency got=%0d exp=34", r_lat); end
    total++; if (r_quot !== 32'd4) begin bad++; $display("FAIL rstmid_next_quot got=%h exp=4", r_quot); end
    total++; if (r_rem !== 32'd1) begin bad++; $display("FAIL rstmid_next_rem got=%h exp=1", r_rem); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_min();
    test_div_zero();
    test_ce_stall();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
